id_branch_unit: RTL
===================

# id_branch_unit

Resolves conditional branches and jump-register instructions in the ID stage, using the `ForwardA_ID`/`ForwardB_ID` selects from the ID-stage forwarding control to pick current operands. Inserts 1–2 stall cycles when a control instruction's source register is still being produced in EX or by a load. Drives PC redirect, IF/ID flush and ID/EX bubble. Sits between the ID-stage forwarding control and the PC/IF-ID registers.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-low reset
- `branch_op`  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 none
- `jump_reg`  in  1  ID instruction is jr/jalr; overrides `branch_op`
- `if_id_rs_addr`, `if_id_rt_addr`  in  5 each  ID source registers
- `if_id_pc_plus4`  in  32  PC+4 of the ID instruction
- `if_id_imm16`  in  16  branch offset
- `ForwardA_ID`, `ForwardB_ID`  in  2 each  00 `rf_*_data`, 10 `ex_mem_alu_out`, 01 `mem_wb_write_data`
- `rf_rs_data`, `rf_rt_data`  in  32 each  register-file reads
- `ex_mem_alu_out`, `mem_wb_write_data`  in  32 each  forwarding sources
- `id_ex_RegWrite`, `id_ex_MemRead`  in  1 each  producer in EX
- `id_ex_write_addr`  in  5
- `ex_mem_MemRead`  in  1  load in MEM
- `ex_mem_write_addr`  in  5
- `branch_taken`  out  1  redirect PC this cycle
- `pc_target`  out  32  redirect address
- `stall`  out  1  hold PC and IF/ID
- `if_id_flush`  out  1  squash the instruction in IF
- `id_ex_bubble`  out  1  insert NOP into ID/EX
- `branch_count`, `taken_count`  out  32 each  statistics (see Configuration)

## Operation
- Control instruction (ctl): `jump_reg`=1, or `branch_op` in 001–110.
- Operands: `opA` selected by `ForwardA_ID`, `opB` by `ForwardB_ID`. Code 11 selects the register file.
- Uses: rs is used by every ctl. rt is used only by beq/bne. A use of register 0 never hazards.
- Hazard need N, evaluated in IDLE:
  - N=2: `id_ex_MemRead` and `id_ex_write_addr` matches a used source.
  - N=1: `id_ex_RegWrite` and match (non-load), or `ex_mem_MemRead` and `ex_mem_write_addr` matches.
  - N=0: otherwise.
- FSM states IDLE and HOLD.
  - IDLE, ctl, N=0: resolve. `stall`=0.
  - IDLE, ctl, N=1: `stall`=1 for this cycle; stay IDLE and re-evaluate next cycle.
  - IDLE, ctl, N=2: `stall`=1; go to HOLD.
  - HOLD: `stall`=1 unconditionally, no evaluation; next state IDLE.
- `id_ex_bubble` = `stall`.
- Resolve (ctl and `stall`=0):
  - jr: taken; `pc_target` = `opA`.
  - beq/bne: compare `opA` to `opB`.
  - blez/bgtz/bltz/bgez: signed compare of `opA` against 0.
  - Branch target = `if_id_pc_plus4` + ({{14{imm[15]}},imm,2'b00}), modulo 2^32.
- `if_id_flush` = `branch_taken`. There is no delay slot.
- `branch_taken`=0 while `stall`=1 or when no ctl is present. `pc_target` is don't-care when not taken and is driven to the branch target.

## Timing
- Outputs are combinational from the inputs and state. The only state is the FSM plus the statistics counters.
- Latency:
  - N=0: resolved in the same cycle ID holds the ctl.
  - N=1: resolved 1 cycle later.
  - N=2: resolved 2 cycles later.
- Reset (async, `reset`=0): state IDLE, counters 0. All outputs are 0 while in reset.
- Reset asserted while in HOLD: returns to IDLE. The pending ctl is re-evaluated after reset deassertion.
- Non-ctl in ID while in HOLD cannot occur, because IF/ID is held. HOLD still exits to IDLE after one cycle.

## Configuration
- `BRANCH_STAT_EN` defined:
  - `branch_count` increments on every resolve cycle.
  - `taken_count` increments on every resolve with `branch_taken`=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- `BRANCH_STAT_EN` undefined: both outputs are constant 0 and no counter flops exist.

## Test plan
- beq, `rf_rs_data`=`rf_rt_data`=5, no hazard, pc_plus4=0x100, imm=0x0004 -> same cycle: `branch_taken`=1, `pc_target`=0x110, `if_id_flush`=1, `stall`=0.
- bne with imm=0xFFFF, pc_plus4=0x100, operands 1 vs 2 -> `pc_target`=0xFC, taken. Same instruction with equal operands -> not taken, `if_id_flush`=0.
- jr $8 with `id_ex_MemRead`=1, `id_ex_write_addr`=8:
  - `stall`=1 for 2 cycles (IDLE then HOLD), `id_ex_bubble`=1 in both.
  - Third cycle: `ForwardA_ID`=01, `mem_wb_write_data`=0x400 -> taken, `pc_target`=0x400.
- bgtz $3 with `id_ex_RegWrite`=1 to $3 (ALU) -> 1 stall. Next cycle `ForwardA_ID`=10, `ex_mem_alu_out`=0x80000000 -> not taken (negative).
- beq on $0 with `id_ex_MemRead` to $0 -> no stall. Assert `reset` low during a HOLD cycle -> `stall`=0 immediately, state IDLE.
- With `BRANCH_STAT_EN`: 3 resolved branches, 2 taken -> `branch_count`=3, `taken_count`=2. Preload `taken_count` near saturation (force) -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/id_branch_unit.sv
// ---------------------------------------------------------------------------
// id_branch_unit
//
// Resolves conditional branches (beq/bne/blez/bgtz/bltz/bgez) and jump-register
// instructions (jr/jalr) in the ID stage. Operands come through the ID-stage
// forwarding selects. When a source register of the control instruction is
// still being produced (an ALU result in EX, or a load in EX/MEM), the unit
// stalls IF/ID and bubbles ID/EX for one or two cycles before resolving.
//
// Optional feature macro: BRANCH_STAT_EN
//   defined   -> branch_count / taken_count are saturating statistics counters
//   undefined -> both statistics outputs are constant 0 (no counter flops)
//
// Ports
//   clk, reset               pipeline clock, asynchronous active-low reset
//   branch_op[2:0]           001 beq, 010 bne, 011 blez, 100 bgtz,
//                            101 bltz, 110 bgez, 000/111 none
//   jump_reg                 ID instruction is jr/jalr (overrides branch_op)
//   if_id_rs_addr/rt_addr    ID source register numbers
//   if_id_pc_plus4           PC+4 of the ID instruction
//   if_id_imm16              branch offset in words
//   ForwardA_ID/ForwardB_ID  00/11 reg file, 10 EX/MEM ALU out, 01 MEM/WB data
//   rf_rs_data/rf_rt_data    register-file read data
//   ex_mem_alu_out           forwarding source from EX/MEM
//   mem_wb_write_data        forwarding source from MEM/WB
//   id_ex_RegWrite/MemRead   producer currently in EX
//   id_ex_write_addr         destination of the EX producer
//   ex_mem_MemRead           load currently in MEM
//   ex_mem_write_addr        destination of the MEM load
//   branch_taken, pc_target  PC redirect request and address
//   stall                    hold PC and IF/ID
//   if_id_flush              squash the instruction fetched in IF
//   id_ex_bubble             insert a NOP into ID/EX
//   branch_count/taken_count statistics outputs
// ---------------------------------------------------------------------------
module id_branch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  branch_op,
    input  logic        jump_reg,
    input  logic [4:0]  if_id_rs_addr,
    input  logic [4:0]  if_id_rt_addr,
    input  logic [31:0] if_id_pc_plus4,
    input  logic [15:0] if_id_imm16,
    input  logic [1:0]  ForwardA_ID,
    input  logic [1:0]  ForwardB_ID,
    input  logic [31:0] rf_rs_data,
    input  logic [31:0] rf_rt_data,
    input  logic [31:0] ex_mem_alu_out,
    input  logic [31:0] mem_wb_write_data,
    input  logic        id_ex_RegWrite,
    input  logic        id_ex_MemRead,
    input  logic [4:0]  id_ex_write_addr,
    input  logic        ex_mem_MemRead,
    input  logic [4:0]  ex_mem_write_addr,
    output logic        branch_taken,
    output logic [31:0] pc_target,
    output logic        stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;
    localparam logic [2:0] OP_BGEZ = 3'b110;

    state_t      state, state_next;
    logic        is_ctl;
    logic        uses_rt;
    logic        ex_match, mem_match;
    logic        need_two, need_one;
    logic        stall_int;
    logic        resolve;
    logic        cond_taken;
    logic [31:0] op_a, op_b;
    logic [31:0] branch_target;

    // A control instruction is any jr/jalr or a real branch encoding.
    assign is_ctl  = jump_reg ||
                     (branch_op != 3'b000 && branch_op != 3'b111);

    // Only the two-operand compares read rt; jr and compare-with-zero don't.
    assign uses_rt = !jump_reg && (branch_op == OP_BEQ || branch_op == OP_BNE);

    // Register 0 is hard-wired, so a write to it can never be a dependency.
    assign ex_match  = ((if_id_rs_addr != 5'd0) && (if_id_rs_addr == id_ex_write_addr)) ||
                       (uses_rt && (if_id_rt_addr != 5'd0) &&
                        (if_id_rt_addr == id_ex_write_addr));
    assign mem_match = ((if_id_rs_addr != 5'd0) && (if_id_rs_addr == ex_mem_write_addr)) ||
                       (uses_rt && (if_id_rt_addr != 5'd0) &&
                        (if_id_rt_addr == ex_mem_write_addr));

    // A load in EX needs two cycles before its data can be forwarded to ID;
    // an ALU result in EX or a load in MEM needs one.
    assign need_two = id_ex_MemRead && ex_match;
    assign need_one = (id_ex_RegWrite && !id_ex_MemRead && ex_match) ||
                      (ex_mem_MemRead && mem_match);

    // Operand muxes; the unused code 11 falls back to the register file.
    always_comb begin
        op_a = rf_rs_data;
        unique case (ForwardA_ID)
            2'b10:   op_a = ex_mem_alu_out;
            2'b01:   op_a = mem_wb_write_data;
            default: op_a = rf_rs_data;
        endcase
    end

    always_comb begin
        op_b = rf_rt_data;
        unique case (ForwardB_ID)
            2'b10:   op_b = ex_mem_alu_out;
            2'b01:   op_b = mem_wb_write_data;
            default: op_b = rf_rt_data;
        endcase
    end

    // Branch condition evaluation; jr/jalr is always taken.
    always_comb begin
        cond_taken = 1'b0;
        if (jump_reg) begin
            cond_taken = 1'b1;
        end else begin
            case (branch_op)
                OP_BEQ:  cond_taken = (op_a == op_b);
                OP_BNE:  cond_taken = (op_a != op_b);
                OP_BLEZ: cond_taken = ($signed(op_a) <= 32'sd0);
                OP_BGTZ: cond_taken = ($signed(op_a) >  32'sd0);
                OP_BLTZ: cond_taken = ($signed(op_a) <  32'sd0);
                OP_BGEZ: cond_taken = ($signed(op_a) >= 32'sd0);
                default: cond_taken = 1'b0;
            endcase
        end
    end

    assign branch_target = if_id_pc_plus4 + {{14{if_id_imm16[15]}}, if_id_imm16, 2'b00};

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall/resolve decode. A one-cycle hazard simply stays in
    // IDLE and re-evaluates; a load-use hazard parks in HOLD for a blind cycle.
    always_comb begin
        state_next = state;
        stall_int  = 1'b0;
        resolve    = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_ctl) begin
                    if (need_two) begin
                        stall_int  = 1'b1;
                        state_next = HOLD;
                    end else if (need_one) begin
                        stall_int  = 1'b1;
                    end else begin
                        resolve    = 1'b1;
                    end
                end
            end
            HOLD: begin
                stall_int  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is held, including the
    // combinational paths that would otherwise react to a ctl in ID.
    assign branch_taken = reset && resolve && cond_taken;
    assign stall        = reset && stall_int;
    assign id_ex_bubble = stall;
    assign if_id_flush  = branch_taken;
    assign pc_target    = !reset   ? 32'd0 :
                          jump_reg ? op_a  : branch_target;

`ifdef BRANCH_STAT_EN
    logic [31:0] branch_q;
    logic [31:0] taken_q;

    // Saturating resolve/taken counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_q <= 32'd0;
            taken_q  <= 32'd0;
        end else begin
            if (resolve && (branch_q != 32'hFFFF_FFFF)) begin
                branch_q <= branch_q + 32'd1;
            end
            if (resolve && cond_taken && (taken_q != 32'hFFFF_FFFF)) begin
                taken_q <= taken_q + 32'd1;
            end
        end
    end

    assign branch_count = branch_q;
    assign taken_count  = taken_q;
`else
    assign branch_count = 32'd0;
    assign taken_count  = 32'd0;
`endif

endmodule
